// File: rtl/rule_match_collector.sv
// Per-packet collector for the port-group checker match stream: drops consecutive
// duplicate rule IDs, buffers survivors and closes every packet with one last entry.
module rule_match_collector #(
  parameter int RULE_AWIDTH  = 16,
  parameter int FIFO_DEPTH   = 32,
  parameter int EOP_DELAY    = 18,
  parameter int AFULL_MARGIN = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_match,
  input  logic [RULE_AWIDTH-1:0] in_rule_id,
  input  logic                   in_eop,
  output logic                   in_afull,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RULE_AWIDTH-1:0] out_rule_id,
  output logic                   out_last,
  output logic [31:0]            match_cnt,
  output logic [31:0]            dup_cnt,
  output logic [31:0]            drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MARGIN_C = CW'(AFULL_MARGIN);

  logic [EOP_DELAY-1:0]   eop_sr_q, eop_sr_d;
  logic                   eop_d;

  logic [RULE_AWIDTH:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          mem_cnt;
  logic                   mem_empty;
  logic                   mem_we;

  logic                   out_valid_q, out_valid_d;
  logic [RULE_AWIDTH-1:0] out_id_q, out_id_d;
  logic                   out_last_q, out_last_d;

  logic [RULE_AWIDTH-1:0] prev_id_q, prev_id_d;
  logic                   prev_vld_q, prev_vld_d;
  logic                   pend_q, pend_d;
  logic                   afull_q, afull_d;

  logic [31:0]            match_cnt_q, match_cnt_d;
  logic [31:0]            dup_cnt_q, dup_cnt_d;
  logic [31:0]            drop_cnt_q, drop_cnt_d;

  logic                   rd, space, is_dup;
  logic                   wr_match, wr_term, wr_en, load_out;
  logic                   match_inc, dup_inc;
  logic [1:0]             drop_inc;
  logic [RULE_AWIDTH:0]   wr_data;

  generate
    if (EOP_DELAY == 1) begin : g_eop_single
      assign eop_sr_d = in_eop;
    end else begin : g_eop_multi
      assign eop_sr_d = {eop_sr_q[EOP_DELAY-2:0], in_eop};
    end
  endgenerate

  assign eop_d     = eop_sr_q[EOP_DELAY-1];
  // cnt_q counts the output register too; the memory holds everything behind it
  assign mem_cnt   = cnt_q - CW'(out_valid_q);
  assign mem_empty = (mem_cnt == '0);

  always_comb begin
    rd        = out_valid_q & out_ready;
    space     = (cnt_q != DEPTH_C) | rd;
    is_dup    = prev_vld_q & (in_rule_id == prev_id_q);
    wr_match  = 1'b0;
    wr_term   = 1'b0;
    pend_d    = pend_q;
    match_inc = 1'b0;
    dup_inc   = 1'b0;
    drop_inc  = 2'd0;

    if (pend_q) begin
      // older terminator still owed: nothing newer may overtake it
      drop_inc = {1'b0, in_match} + {1'b0, eop_d};
      if (space) begin
        wr_term = 1'b1;
        pend_d  = 1'b0;
      end
    end else begin
      if (in_match) begin
        if (is_dup) begin
          dup_inc = 1'b1;
        end else if (space) begin
          wr_match  = 1'b1;
          match_inc = 1'b1;
        end else begin
          drop_inc = 2'd1;
        end
      end
      if (eop_d && !wr_match) begin
        if (space) wr_term = 1'b1;
        else       pend_d  = 1'b1;
      end
    end

    wr_en   = wr_match | wr_term;
    wr_data = wr_match ? {eop_d, in_rule_id} : {1'b1, {RULE_AWIDTH{1'b0}}};

    prev_id_d  = wr_match ? in_rule_id : prev_id_q;
    prev_vld_d = eop_d ? 1'b0 : (wr_match | prev_vld_q);

    cnt_d = cnt_q + CW'(wr_en) - CW'(rd);

    load_out    = ~out_valid_q | rd;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    mem_we      = 1'b0;

    if (load_out) begin
      if (!mem_empty) begin
        {out_last_d, out_id_d} = mem_q[rd_ptr_q];
        out_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + AW'(1);
        mem_we      = wr_en;
      end else if (wr_en) begin
        // empty queue: the new entry goes straight to the output register
        {out_last_d, out_id_d} = wr_data;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      mem_we = wr_en;
    end
    if (mem_we) wr_ptr_d = wr_ptr_q + AW'(1);

    afull_d = ((DEPTH_C - cnt_d) <= MARGIN_C) | pend_d;

    match_cnt_d = match_cnt_q + 32'(match_inc);
    dup_cnt_d   = dup_cnt_q + 32'(dup_inc);
    drop_cnt_d  = drop_cnt_q + 32'(drop_inc);
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eop_sr_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
      prev_id_q   <= '0;
      prev_vld_q  <= 1'b0;
      pend_q      <= 1'b0;
      afull_q     <= 1'b0;
      match_cnt_q <= '0;
      dup_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      eop_sr_q    <= eop_sr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
      prev_id_q   <= prev_id_d;
      prev_vld_q  <= prev_vld_d;
      pend_q      <= pend_d;
      afull_q     <= afull_d;
      match_cnt_q <= match_cnt_d;
      dup_cnt_q   <= dup_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign in_afull    = afull_q;
  assign out_valid   = out_valid_q;
  assign out_rule_id = out_id_q;
  assign out_last    = out_last_q;
  assign match_cnt   = match_cnt_q;
  assign dup_cnt     = dup_cnt_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_rule_match_collector.sv
// Bench for rule_match_collector: directed packets plus random traffic, each cycle
// checked against a queue-based model of the collector's packet rules.
module tb_rule_match_collector;

  localparam int RW     = 16;
  localparam int DEPTH  = 32;
  localparam int DLY    = 18;
  localparam int MARGIN = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_match = 1'b0;
  logic [RW-1:0] in_rule_id = '0;
  logic          in_eop = 1'b0;
  logic          in_afull;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_rule_id;
  logic          out_last;
  logic [31:0]   match_cnt, dup_cnt, drop_cnt;

  rule_match_collector #(
    .RULE_AWIDTH(RW), .FIFO_DEPTH(DEPTH), .EOP_DELAY(DLY), .AFULL_MARGIN(MARGIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_match(in_match), .in_rule_id(in_rule_id),
    .in_eop(in_eop), .in_afull(in_afull), .out_valid(out_valid), .out_ready(out_ready),
    .out_rule_id(out_rule_id), .out_last(out_last), .match_cnt(match_cnt),
    .dup_cnt(dup_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model state: pending output entries {last,id}, packet bookkeeping, counters
  logic [RW:0]   q[$];
  int            eop_t[$];
  int            cyc = 0;
  bit            m_pend = 0;
  bit            m_pvld = 0;
  logic [RW-1:0] m_prev = '0;
  int unsigned   m_match = 0, m_dup = 0, m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    q.delete();
    eop_t.delete();
    m_pend = 0; m_pvld = 0; m_prev = '0;
    m_match = 0; m_dup = 0; m_drop = 0;
  endtask

  task automatic cycle(input bit m, input logic [RW-1:0] id, input bit e, input bit r);
    bit eopd, rd, wrote;
    logic [RW:0] ent;
    in_match = m; in_rule_id = id; in_eop = e; out_ready = r;
    eopd = 0;
    if (eop_t.size() > 0 && eop_t[0] + DLY == cyc) begin
      eopd = 1;
      void'(eop_t.pop_front());
    end
    if (e) eop_t.push_back(cyc);

    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      ent = q[0];
      chk("out_rule_id", 32'(out_rule_id), 32'(ent[RW-1:0]));
      chk("out_last", 32'(out_last), 32'(ent[RW]));
    end
    chk("in_afull", 32'(in_afull), 32'(((DEPTH - q.size()) <= MARGIN) || m_pend));
    chk("match_cnt", match_cnt, m_match);
    chk("dup_cnt", dup_cnt, m_dup);
    chk("drop_cnt", drop_cnt, m_drop);

    rd = r && (q.size() > 0);
    if (rd) void'(q.pop_front());
    wrote = 0;
    if (m_pend) begin
      if (m) m_drop++;
      if (eopd) m_drop++;
      if (q.size() < DEPTH) begin
        q.push_back({1'b1, {RW{1'b0}}});
        m_pend = 0;
      end
    end else begin
      if (m) begin
        if (m_pvld && id == m_prev) m_dup++;
        else if (q.size() < DEPTH) begin
          q.push_back({eopd, id});
          wrote = 1;
          m_match++;
          m_prev = id;
          m_pvld = 1;
        end else m_drop++;
      end
      if (eopd && !wrote) begin
        if (q.size() < DEPTH) q.push_back({1'b1, {RW{1'b0}}});
        else m_pend = 1;
      end
    end
    if (eopd) m_pvld = 0;
    cyc++;
  endtask

  task automatic step(input bit m, input logic [RW-1:0] id, input bit e, input bit r);
    @(negedge clk);
    cycle(m, id, e, r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    in_match = 1'b0; in_eop = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_rule_id", 32'(out_rule_id), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_in_afull", 32'(in_afull), 32'd0);
    chk("rst_match_cnt", match_cnt, 32'd0);
    chk("rst_dup_cnt", dup_cnt, 32'd0);
    chk("rst_drop_cnt", drop_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    cycle(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    repeat (DLY + DEPTH + 8) step(1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [RW-1:0] ids_a [4];
    logic [RW-1:0] rid;
    bit            m, e, r;
    ids_a[0] = 16'd5; ids_a[1] = 16'd7; ids_a[2] = 16'd7; ids_a[3] = 16'd9;

    repeat (2) @(negedge clk);
    chk("por_out_valid", 32'(out_valid), 32'd0);
    chk("por_in_afull", 32'(in_afull), 32'd0);
    rst_n = 1'b1;

    // packet 5,7,7,9 with eop at cycle 0 of the packet
    for (int c = 0; c < 40; c++)
      step(c >= 3 && c <= 6, (c >= 3 && c <= 6) ? ids_a[c-3] : 16'd0, c == 0, 1'b1);
    chk("pktA_dup_cnt", dup_cnt, 32'd1);
    chk("pktA_match_cnt", match_cnt, 32'd3);

    // match coincident with eop_d, then a packet without matches
    for (int c = 0; c < 40; c++)
      step(c == DLY, (c == DLY) ? 16'd12 : 16'd0, c == 0 || c == 5, 1'b1);

    // overflow: 40 unique matches against a stalled consumer
    do_reset();
    for (int c = 0; c < 50; c++)
      step(c < 40, 16'(100 + c), c == 25, 1'b0);
    chk("ovf_drop_cnt", drop_cnt, 32'd8);
    chk("ovf_match_cnt", match_cnt, 32'd32);
    chk("ovf_afull", 32'(in_afull), 32'd1);
    drain();

    // full FIFO with a simultaneous read and write
    do_reset();
    for (int c = 0; c < 32; c++) step(1'b1, 16'(200 + c), 1'b0, 1'b0);
    step(1'b1, 16'd300, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("fullrw_drop_cnt", drop_cnt, 32'd0);
    chk("fullrw_match_cnt", match_cnt, 32'd33);
    drain();

    // reset with entries buffered, then a clean packet
    for (int c = 0; c < 10; c++) step(1'b1, 16'(400 + c), 1'b0, 1'b0);
    do_reset();
    for (int c = 0; c < 30; c++)
      step(c == 3 || c == 4, 16'(21 + c - 3), c == 0, 1'b1);

    // same ID at the end of one packet and the start of the next
    for (int c = 0; c < 40; c++)
      step(c == DLY || c == DLY + 1, 16'd4, c == 0 || c == 2, 1'b1);
    chk("boundary_dup_cnt", dup_cnt, 32'd0);

    // random traffic: light, heavy backpressure, mixed
    for (int i = 0; i < 2500; i++) begin
      m   = ($urandom_range(99) < 60);
      rid = 16'($urandom_range(6, 1));
      e   = ($urandom_range(15) == 0);
      if (i < 1000)      r = ($urandom_range(99) < 85);
      else if (i < 1800) r = ($urandom_range(99) < 15);
      else               r = ($urandom_range(99) < 70);
      step(m, rid, e, r);
    end
    drain();
    chk("final_empty", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
